mytimer2: RTL and testbench

- Parametrised multi-channel down-counting timer; successor to the single-event interrupt timer.
- Sits on the memory-mapped slave bus alongside the other peripherals.
- Drives one level interrupt to the CPU interrupt controller.
- Adds per-channel load value, one-shot/periodic mode, interrupt enable, a shared prescaler and a readable current count.

---
 rtl/mytimer2_pkg.sv | 19 +
 rtl/mytimer2_if.sv | 26 ++
 rtl/mytimer2_channel.sv | 82 ++++++++
 rtl/mytimer2.sv | 115 +++++++++++
 tb/tb_mytimer2.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mytimer2_pkg.sv
// Shared constants for the mytimer2 multi-channel timer: register offsets
// and bit positions inside the CTRL and STATUS registers.
package mytimer2_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_LOAD   = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;
  localparam int CTRL_W        = 3;

  localparam int STATUS_EXP = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/mytimer2_if.sv
// Memory-mapped slave bus used by mytimer2; CH sets the address width
// (two offset bits plus the channel index).
interface mytimer2_if #(
  parameter int CH = 2
) ();

  localparam int AW = $clog2(CH) + 2;

  logic          s_cs_n;
  logic [AW-1:0] s_address;
  logic          s_read;
  logic [31:0]   s_readdata;
  logic          s_write;
  logic [31:0]   s_writedata;

  modport master (
    output s_cs_n, s_address, s_read, s_write, s_writedata,
    input  s_readdata
  );

  modport slave (
    input  s_cs_n, s_address, s_read, s_write, s_writedata,
    output s_readdata
  );

endinterface

// File: rtl/mytimer2_channel.sv
// One down-counting timer channel: CTRL/LOAD/COUNT registers and the sticky
// expiry flag, advanced on each prescaler tick.
module mytimer2_channel
  import mytimer2_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick,
  input  logic         wr_ctrl,
  input  logic         wr_load,
  input  logic         wr_status,
  input  logic [W-1:0] wdata,
  output ctrl_t        ctrl,
  output logic [W-1:0] load,
  output logic [W-1:0] count,
  output logic         exp
);

  ctrl_t        ctrl_q, ctrl_d;
  logic [W-1:0] load_q, load_d;
  logic [W-1:0] count_q, count_d;
  logic         exp_q, exp_d;

  // Order matters: a status clear is overridden by an expiry on the same
  // edge, and a CTRL write overrides the one-shot hardware EN clear.
  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;

    if (wr_status && wdata[STATUS_EXP]) begin
      exp_d = 1'b0;
    end

    if (tick && ctrl_q[CTRL_EN]) begin
      if (count_q != '0) begin
        count_d = count_q - W'(1);
      end else begin
        exp_d = 1'b1;
        if (ctrl_q[CTRL_PERIODIC]) begin
          count_d = load_q;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
        end
      end
    end

    if (wr_ctrl) begin
      ctrl_d = wdata[CTRL_W-1:0];
      if (wdata[CTRL_EN] && !ctrl_q[CTRL_EN]) begin
        count_d = load_q;
      end
    end

    if (wr_load) begin
      load_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      exp_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
    end
  end

  assign ctrl  = ctrl_q;
  assign load  = load_q;
  assign count = count_q;
  assign exp   = exp_q;

endmodule

// File: rtl/mytimer2.sv
// Multi-channel down-counting timer: shared prescaler, bus decode, read mux
// and a registered level interrupt built from the per-channel expiry flags.
module mytimer2
  import mytimer2_pkg::*;
#(
  parameter int CH       = 2,
  parameter int W        = 32,
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        irq,
  mytimer2_if.slave   bus
);

  localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic          irq_q, irq_d;

  logic [31:0]   ch_idx;
  logic [1:0]    offset;
  logic          wr_en;
  logic          rd_en;

  logic [CH-1:0] wr_ctrl, wr_load, wr_status;
  logic [CH-1:0] exp_vec, ie_vec;
  ctrl_t         ctrl_arr  [CH];
  logic [W-1:0]  load_arr  [CH];
  logic [W-1:0]  count_arr [CH];

  // With PRESCALE=1 the counter never leaves 0, so tick is held high.
  always_comb begin
    tick  = (pre_q == PRE_MAX);
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  always_comb begin
    ch_idx    = 32'(bus.s_address) >> 2;
    offset    = bus.s_address[1:0];
    wr_en     = !bus.s_cs_n && bus.s_write;
    rd_en     = !bus.s_cs_n && bus.s_read;
    wr_ctrl   = '0;
    wr_load   = '0;
    wr_status = '0;
    for (int i = 0; i < CH; i++) begin
      if (wr_en && (ch_idx == 32'(i))) begin
        case (offset)
          OFF_CTRL:   wr_ctrl[i]   = 1'b1;
          OFF_LOAD:   wr_load[i]   = 1'b1;
          OFF_STATUS: wr_status[i] = 1'b1;
          default:    ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    mytimer2_channel #(
      .W(W)
    ) u_channel (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .wr_ctrl   (wr_ctrl[g]),
      .wr_load   (wr_load[g]),
      .wr_status (wr_status[g]),
      .wdata     (bus.s_writedata[W-1:0]),
      .ctrl      (ctrl_arr[g]),
      .load      (load_arr[g]),
      .count     (count_arr[g]),
      .exp       (exp_vec[g])
    );
  end

  // Out-of-range channel indices match no loop iteration and read as 0.
  always_comb begin
    bus.s_readdata = '0;
    if (rd_en) begin
      for (int i = 0; i < CH; i++) begin
        if (ch_idx == 32'(i)) begin
          case (offset)
            OFF_CTRL:   bus.s_readdata = {{(32-CTRL_W){1'b0}}, ctrl_arr[i]};
            OFF_LOAD:   bus.s_readdata = 32'(load_arr[i]);
            OFF_COUNT:  bus.s_readdata = 32'(count_arr[i]);
            OFF_STATUS: bus.s_readdata = {31'd0, exp_vec[i]};
            default:    bus.s_readdata = '0;
          endcase
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      ie_vec[i] = ctrl_arr[i][CTRL_IE];
    end
    irq_d = |(exp_vec & ie_vec);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      irq_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_mytimer2.sv
// Self-checking bench for mytimer2: two instances (CH=3/PRESCALE=1 and
// CH=2/PRESCALE=4); register reads are scored through an expected-value queue.
module tb_mytimer2;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  logic clk;
  logic reset_n;
  logic irq_a;
  logic irq_b;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  sb_t  sbq[$];

  mytimer2_if #(.CH(3)) if_a ();
  mytimer2_if #(.CH(2)) if_b ();

  mytimer2 #(.CH(3), .W(32), .PRESCALE(1)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .irq     (irq_a),
    .bus     (if_a)
  );

  mytimer2 #(.CH(2), .W(32), .PRESCALE(4)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .irq     (irq_b),
    .bus     (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic irqOf(input bit sel);
    return sel ? irq_b : irq_a;
  endfunction

  task automatic applyStimulus(input bit sel, input bit cs_n, input bit rd,
                               input bit wr, input logic [3:0] addr,
                               input logic [31:0] wdata);
    if (sel) begin
      if_b.s_cs_n      = cs_n;
      if_b.s_read      = rd;
      if_b.s_write     = wr;
      if_b.s_address   = addr[2:0];
      if_b.s_writedata = wdata;
    end else begin
      if_a.s_cs_n      = cs_n;
      if_a.s_read      = rd;
      if_a.s_write     = wr;
      if_a.s_address   = addr;
      if_a.s_writedata = wdata;
    end
  endtask

  task automatic busIdle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic busWrite(input bit sel, input logic [3:0] addr,
                          input logic [31:0] data);
    applyStimulus(sel, 1'b0, 1'b0, 1'b1, addr, data);
    @(negedge clk);
    busIdle();
  endtask

  task automatic busReadRaw(input bit sel, input logic [3:0] addr,
                            input bit cs_n, input bit rd,
                            input logic [31:0] expv, input string tag);
    sb_t e;
    sb_t got;
    applyStimulus(sel, cs_n, rd, 1'b0, addr, 32'd0);
    e.tag = tag;
    e.val = expv;
    sbq.push_back(e);
    #2;
    got = sbq.pop_front();
    checkOutput(got.tag, sel ? if_b.s_readdata : if_a.s_readdata, got.val);
    @(negedge clk);
    busIdle();
  endtask

  task automatic busRead(input bit sel, input logic [3:0] addr,
                         input logic [31:0] expv, input string tag);
    busReadRaw(sel, addr, 1'b0, 1'b1, expv, tag);
  endtask

  task automatic checkIrq(input bit sel, input bit expv, input string tag);
    checkOutput(tag, 32'(irqOf(sel)), 32'(expv));
  endtask

  task automatic waitIrqRise(input bit sel, input string tag, output int stamp);
    int n;
    stamp = -1;
    n = 0;
    while (irqOf(sel) !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checkOutput({tag, "_low_timeout"}, 32'(irqOf(sel)), 32'd0);
      return;
    end
    n = 0;
    while (irqOf(sel) !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checkOutput({tag, "_high_timeout"}, 32'(irqOf(sel)), 32'd1);
      return;
    end
    stamp = cyc;
  endtask

  initial begin
    int t1, t2, t3, t4, t5;
    reset_n = 1'b0;
    busIdle();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state of every register on both instances.
    checkIrq(1'b0, 1'b0, "a_rst_irq");
    checkIrq(1'b1, 1'b0, "b_rst_irq");
    for (int a = 0; a < 8; a++) busRead(1'b1, 4'(a), 32'd0, $sformatf("b_rst_%0d", a));
    for (int a = 0; a < 12; a++) busRead(1'b0, 4'(a), 32'd0, $sformatf("a_rst_%0d", a));

    // One-shot with IE on channel 0: LOAD=3.
    busWrite(1'b0, 4'd1, 32'd3);
    busWrite(1'b0, 4'd0, 32'h5);
    busRead(1'b0, 4'd2, 32'd3, "os_cnt3");
    busRead(1'b0, 4'd2, 32'd2, "os_cnt2");
    busRead(1'b0, 4'd2, 32'd1, "os_cnt1");
    busRead(1'b0, 4'd2, 32'd0, "os_cnt0");
    checkIrq(1'b0, 1'b0, "os_irq_not_yet");
    busRead(1'b0, 4'd3, 32'd1, "os_exp");
    checkIrq(1'b0, 1'b1, "os_irq");
    busRead(1'b0, 4'd0, 32'h4, "os_ctrl_en_cleared");
    busRead(1'b0, 4'd2, 32'd0, "os_cnt_stays0");
    busWrite(1'b0, 4'd3, 32'd1);
    checkIrq(1'b0, 1'b1, "os_irq_hold_after_clr");
    busRead(1'b0, 4'd3, 32'd0, "os_exp_cleared");
    checkIrq(1'b0, 1'b0, "os_irq_dropped");

    // Periodic with IE on channel 1: LOAD=1, period 2 ticks.
    busWrite(1'b0, 4'd5, 32'd1);
    busWrite(1'b0, 4'd4, 32'h7);
    busRead(1'b0, 4'd6, 32'd1, "per_cnt1");
    busRead(1'b0, 4'd6, 32'd0, "per_cnt0");
    checkIrq(1'b0, 1'b0, "per_irq_not_yet");
    busRead(1'b0, 4'd7, 32'd1, "per_exp1");
    checkIrq(1'b0, 1'b1, "per_irq1");
    busRead(1'b0, 4'd6, 32'd0, "per_cnt_reloaded");
    busWrite(1'b0, 4'd7, 32'd1);
    checkIrq(1'b0, 1'b1, "per_irq_hold");
    busRead(1'b0, 4'd7, 32'd0, "per_exp_cleared");
    checkIrq(1'b0, 1'b0, "per_irq_dropped");
    busRead(1'b0, 4'd7, 32'd1, "per_exp2");
    checkIrq(1'b0, 1'b1, "per_irq_reassert");
    busWrite(1'b0, 4'd7, 32'd1);
    checkIrq(1'b0, 1'b1, "per_clr_on_exp_irq");
    busRead(1'b0, 4'd7, 32'd1, "per_clr_on_exp_keeps");
    busWrite(1'b0, 4'd4, 32'd0);
    busWrite(1'b0, 4'd7, 32'd1);
    idleCycles(3);
    checkIrq(1'b0, 1'b0, "per_stopped_irq");

    // Prescaler 4 on instance B: LOAD=2 gives 12 clocks, LOAD=0 gives 4.
    busWrite(1'b1, 4'd1, 32'd2);
    busWrite(1'b1, 4'd0, 32'h7);
    waitIrqRise(1'b1, "ps_rise1", t1);
    busWrite(1'b1, 4'd3, 32'd1);
    waitIrqRise(1'b1, "ps_rise2", t2);
    checkOutput("ps_period12", 32'(t2 - t1), 32'd12);
    busWrite(1'b1, 4'd3, 32'd1);
    busWrite(1'b1, 4'd1, 32'd0);
    waitIrqRise(1'b1, "ps_rise3", t3);
    checkOutput("ps_period_completes", 32'(t3 - t2), 32'd12);
    busWrite(1'b1, 4'd3, 32'd1);
    waitIrqRise(1'b1, "ps_rise4", t4);
    checkOutput("ps_period4", 32'(t4 - t3), 32'd4);
    busWrite(1'b1, 4'd3, 32'd1);
    waitIrqRise(1'b1, "ps_rise5", t5);
    checkOutput("ps_period4b", 32'(t5 - t4), 32'd4);
    busWrite(1'b1, 4'd0, 32'd0);
    busWrite(1'b1, 4'd3, 32'd1);

    // Expiry with IE=0, then enabling IE afterwards.
    busWrite(1'b0, 4'd1, 32'd2);
    busWrite(1'b0, 4'd0, 32'h1);
    idleCycles(4);
    checkIrq(1'b0, 1'b0, "noie_irq");
    busRead(1'b0, 4'd3, 32'd1, "noie_exp");
    busRead(1'b0, 4'd0, 32'd0, "noie_ctrl");
    busRead(1'b0, 4'd2, 32'd0, "noie_cnt");
    busWrite(1'b0, 4'd0, 32'h4);
    checkIrq(1'b0, 1'b0, "ie_set_irq_edge");
    @(negedge clk);
    checkIrq(1'b0, 1'b1, "ie_set_irq_next");

    // Out-of-range channel 3, COUNT write, read gating, LOAD width.
    busWrite(1'b0, 4'd13, 32'hFFFF_FFFF);
    busWrite(1'b0, 4'd12, 32'h7);
    busRead(1'b0, 4'd12, 32'd0, "inv_ctrl");
    busRead(1'b0, 4'd13, 32'd0, "inv_load");
    busRead(1'b0, 4'd8, 32'd0, "ch2_ctrl_untouched");
    busRead(1'b0, 4'd9, 32'd0, "ch2_load_untouched");
    busWrite(1'b0, 4'd9, 32'hDEAD_BEEF);
    busRead(1'b0, 4'd9, 32'hDEAD_BEEF, "ch2_load_rb");
    busWrite(1'b0, 4'd10, 32'd5);
    busRead(1'b0, 4'd10, 32'd0, "count_ro");
    busReadRaw(1'b0, 4'd9, 1'b1, 1'b1, 32'd0, "gate_cs");
    busReadRaw(1'b0, 4'd9, 1'b0, 1'b0, 32'd0, "gate_rd");
    checkIrq(1'b0, 1'b1, "inv_irq_unchanged");

    // Asynchronous reset mid-count with irq asserted.
    busWrite(1'b0, 4'd5, 32'd5);
    busWrite(1'b0, 4'd4, 32'h7);
    idleCycles(2);
    checkIrq(1'b0, 1'b1, "prerst_irq");
    #2 reset_n = 1'b0;
    #1;
    checkIrq(1'b0, 1'b0, "async_rst_irq");
    @(negedge clk);
    busRead(1'b0, 4'd6, 32'd0, "rst_cnt1");
    busRead(1'b0, 4'd3, 32'd0, "rst_exp0");
    busRead(1'b0, 4'd4, 32'd0, "rst_ctrl1");
    busRead(1'b0, 4'd9, 32'd0, "rst_load2");
    reset_n = 1'b1;
    idleCycles(5);
    busRead(1'b0, 4'd6, 32'd0, "post_rst_idle_cnt");
    busRead(1'b0, 4'd4, 32'd0, "post_rst_idle_ctrl");
    busWrite(1'b0, 4'd5, 32'd3);
    busWrite(1'b0, 4'd4, 32'h1);
    busRead(1'b0, 4'd6, 32'd3, "restart_cnt3");
    busRead(1'b0, 4'd6, 32'd2, "restart_cnt2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
